serial_byte_adder_ctrl: RTL

- Sequencer that performs wide (8*NBYTES-bit) add/subtract by time-multiplexing one external 8-bit adder slice (carry-bypass adder8), one byte per cycle, LSB first.
- Holds operands and a carry register; drives the slice, captures its sum/cout and returns the full result over valid/ready handshakes.
- Sits between a requesting datapath and a shared adder8 instance.

---
 rtl/serial_byte_adder_ctrl_if.sv | 44 ++++
 rtl/serial_byte_adder_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/serial_byte_adder_ctrl_if.sv
// Bundle of request, response and adder-slice signals for serial_byte_adder_ctrl.
// The slave modport is the controller; master is the requester; slice is the shared adder8.
interface serial_byte_adder_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. The payload is stable while valid is high, and valid is never withdrawn
  // before its transfer completes.
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;

  logic [7:0]    slice_a;
  logic [7:0]    slice_b;
  logic          slice_cin;
  logic [7:0]    slice_sum;
  logic          slice_cout;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready, slice_sum, slice_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, slice_a, slice_b, slice_cin
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slice (
    input  slice_a, slice_b, slice_cin,
    output slice_sum, slice_cout
  );
endinterface

// File: rtl/serial_byte_adder_ctrl.sv
// Wide add/subtract sequenced one byte per cycle, LSB first, through a shared
// external 8-bit adder slice. Operands are latched on accept; result held until taken.
module serial_byte_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_byte_adder_ctrl_if.slave   bus,
  output logic                      busy,
  output logic [1:0]                state_dbg
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    carry;
  logic [NBYTES-1:0][7:0]  a_q;
  logic [NBYTES-1:0][7:0]  b_q;
  logic [NBYTES-1:0][7:0]  res_q;
  logic [W-1:0]            sum_q;
  logic                    cout_q;
  logic                    ovf_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    last_byte;

  assign last_byte = (idx == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1, so the carry register doubles as the +1.
            a_q    <= bus.in_a;
            b_q    <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry  <= bus.in_sub | bus.in_cin;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_q[idx] <= bus.slice_sum;
          carry      <= bus.slice_cout;
          if (last_byte) begin
            // The top byte comes straight from the slice; lower bytes from res_q.
            sum_q   <= {bus.slice_sum, res_q[NBYTES-2:0]};
            cout_q  <= bus.slice_cout;
            ovf_q   <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                       (bus.slice_sum[7] != a_q[NBYTES-1][7]);
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // The slice is quiet outside RUN so a shared adder sees no stray activity.
  always_comb begin
    bus.slice_a   = 8'h00;
    bus.slice_b   = 8'h00;
    bus.slice_cin = 1'b0;
    if (state == RUN) begin
      bus.slice_a   = a_q[idx];
      bus.slice_b   = b_q[idx];
      bus.slice_cin = carry;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = busy_q;
  assign state_dbg     = state;
endmodule
